mult: RTL and testbench



---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_pp_row.sv | 38 +++
 rtl/mult.sv | 70 +++++++
 tb/tb_mult.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the pipelined array multiplier.
package mult_pkg;

  // Default operand width of the ALU datapath.
  localparam int MULT_WIDTH   = 4;
  // Clock edges from a sampled in_valid to the matching out_valid.
  localparam int MULT_LATENCY = 2;

  // PROD_WIDTH = 2*WIDTH: an exact product never needs more bits.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One partial-product row: a gated by a single b bit, shifted to its row index.
// Build option MULT_SIGNED_EN: rows carry Baugh-Wooley inversions and row 0
// also carries the constant correction bits, so the row sum is the two's
// complement product.
module mult_pp_row
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int ROW   = 0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  output logic [2*WIDTH-1:0] row
);

  logic [WIDTH-1:0] bits;

`ifdef MULT_SIGNED_EN
  // Constant 2^WIDTH + 2^(2*WIDTH-1) folded into row 0, whose own bits
  // only occupy positions 0..WIDTH-1.
  localparam logic [2*WIDTH-1:0] CORR =
    (ROW == 0) ? (((2*WIDTH)'(1) << WIDTH) | ((2*WIDTH)'(1) << (2*WIDTH-1)))
               : '0;

  // Invert the terms that pair a sign bit with a non-sign bit.
  always_comb begin
    bits = a & {WIDTH{b_bit}};
    if (ROW == WIDTH-1) bits[WIDTH-2:0] = ~bits[WIDTH-2:0];
    else                bits[WIDTH-1]   = ~bits[WIDTH-1];
  end

  assign row = ({{WIDTH{1'b0}}, bits} << ROW) | CORR;
`else
  assign bits = a & {WIDTH{b_bit}};
  assign row  = {{WIDTH{1'b0}}, bits} << ROW;
`endif

endmodule

// File: rtl/mult.sv
// Two-stage pipelined WIDTH x WIDTH array multiplier with valid qualifier.
// Stage 1 registers the lower-half and upper-half row sums, stage 2 adds them.
// Build option MULT_SIGNED_EN selects two's complement operands and product.
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid
);

  localparam int PROD_WIDTH = prod_width(WIDTH);
  localparam int LO_ROWS    = WIDTH / 2;

  logic [WIDTH-1:0][PROD_WIDTH-1:0] rows;
  logic [PROD_WIDTH-1:0]            lo_next, hi_next;
  logic [PROD_WIDTH-1:0]            sum_lo, sum_hi;
  logic [MULT_LATENCY:1]            vld_pipe;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    mult_pp_row #(.WIDTH(WIDTH), .ROW(i)) u_row (
      .a     (a),
      .b_bit (b[i]),
      .row   (rows[i])
    );
  end

  // Reduce rows into the lower-half and upper-half partial sums.
  always_comb begin
    lo_next = '0;
    hi_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < LO_ROWS) lo_next = lo_next + rows[i];
      else             hi_next = hi_next + rows[i];
    end
  end

  // Valid shift register; a bubble ripples through as a 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[MULT_LATENCY-1:1], in_valid};
  end

  // Stage 1: capture partial sums only for valid inputs, so X on idle
  // operands never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_lo <= '0;
      sum_hi <= '0;
    end else if (in_valid) begin
      sum_lo <= lo_next;
      sum_hi <= hi_next;
    end
  end

  // Stage 2: final add; out holds the last valid product across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           out <= '0;
    else if (vld_pipe[1]) out <= sum_lo + sum_hi;
  end

  assign out_valid = vld_pipe[MULT_LATENCY];

endmodule

// File: tb/tb_mult.sv
// Directed bench for mult (4x4). Inputs change on the falling edge, outputs
// are sampled on the falling edge before new inputs are applied.
module tb_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic [7:0] out;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  mult #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Hand values: u for the unsigned build, s for the signed build.
  function automatic logic [7:0] pick(input logic [7:0] u, input logic [7:0] s);
`ifdef MULT_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
`ifdef MULT_SIGNED_EN
    logic signed [7:0] sx, sy, p;
    sx = {{4{x[3]}}, x};
    sy = {{4{y[3]}}, y};
    p  = sx * sy;
    return p;
`else
    return {4'b0, x} * {4'b0, y};
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    in_valid = v;
    a = x;
    b = y;
  endtask

  // Single vector: apply, idle with X operands, check result then hold.
  task automatic one(input string tag, input logic [3:0] x, input logic [3:0] y,
                     input logic [7:0] exp);
    @(negedge clk); drive(1'b1, x, y);
    @(negedge clk); drive(1'b0, 4'bx, 4'bx);
    chk({tag, "_v_early"}, {7'b0, out_valid}, 8'd0);
    @(negedge clk);
    chk({tag, "_v"}, {7'b0, out_valid}, 8'd1);
    chk({tag, "_out"}, out, exp);
    @(negedge clk);
    chk({tag, "_v_drop"}, {7'b0, out_valid}, 8'd0);
    chk({tag, "_hold"}, out, exp);
  endtask

  initial begin
    // Reset held with in_valid toggling.
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      chk("rst_out", out, 8'h00);
      chk("rst_v", {7'b0, out_valid}, 8'd0);
    end

    // Asynchronous clear in the middle of a cycle.
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 4'hF, 4'hF);
    @(negedge clk); drive(1'b0, 4'h0, 4'h0);
    @(negedge clk);
    chk("pre_arst_v", {7'b0, out_valid}, 8'd1);
    chk("pre_arst_out", out, pick(8'hE1, 8'h01));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", out, 8'h00);
    chk("arst_v", {7'b0, out_valid}, 8'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors and extremes.
    one("d_1x1",   4'b0001, 4'b0001, pick(8'h01, 8'h01));
    one("d_8x2",   4'b1000, 4'b0010, pick(8'h10, 8'hF0));
    one("d_2x2",   4'b0010, 4'b0010, pick(8'h04, 8'h04));
    one("x_fxf",   4'b1111, 4'b1111, pick(8'hE1, 8'h01));
    one("x_0xb",   4'b0000, 4'b1011, pick(8'h00, 8'h00));
    one("x_bx1",   4'b1011, 4'b0001, pick(8'h0B, 8'hFB));
    one("x_8x8",   4'b1000, 4'b1000, pick(8'h40, 8'h40));

    // Streaming: four back-to-back pairs.
    @(negedge clk); drive(1'b1, 4'd3, 4'd5);
    @(negedge clk); drive(1'b1, 4'd7, 4'd9);
    @(negedge clk);
    chk("s0_v", {7'b0, out_valid}, 8'd1);
    chk("s0", out, pick(8'd15, 8'd15));
    drive(1'b1, 4'd12, 4'd12);
    @(negedge clk);
    chk("s1_v", {7'b0, out_valid}, 8'd1);
    chk("s1", out, pick(8'd63, 8'hCF));
    drive(1'b1, 4'd15, 4'd1);
    @(negedge clk);
    chk("s2_v", {7'b0, out_valid}, 8'd1);
    chk("s2", out, pick(8'd144, 8'h10));
    drive(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("s3_v", {7'b0, out_valid}, 8'd1);
    chk("s3", out, pick(8'd15, 8'hFF));
    @(negedge clk);
    chk("s_end_v", {7'b0, out_valid}, 8'd0);
    chk("s_end_hold", out, pick(8'd15, 8'hFF));

    // Bubble between two pairs.
    @(negedge clk); drive(1'b1, 4'd3, 4'd5);
    @(negedge clk); drive(1'b0, 4'd9, 4'd9);
    @(negedge clk);
    chk("b0_v", {7'b0, out_valid}, 8'd1);
    chk("b0", out, pick(8'd15, 8'd15));
    drive(1'b1, 4'd2, 4'd6);
    @(negedge clk);
    chk("bgap_v", {7'b0, out_valid}, 8'd0);
    chk("bgap_hold", out, pick(8'd15, 8'd15));
    drive(1'b0, 4'd0, 4'd0);
    @(negedge clk);
    chk("b1_v", {7'b0, out_valid}, 8'd1);
    chk("b1", out, pick(8'd12, 8'd12));

    // Reset between the input edge and the output edge.
    @(negedge clk); drive(1'b1, 4'd7, 4'd9);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0);
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mr_v", {7'b0, out_valid}, 8'd0);
    chk("mr_out", out, 8'h00);
    @(negedge clk);
    chk("mr_v2", {7'b0, out_valid}, 8'd0);
    drive(1'b1, 4'd5, 4'd5);
    @(negedge clk); drive(1'b0, 4'd0, 4'd0);
    chk("mr_first_early", {7'b0, out_valid}, 8'd0);
    @(negedge clk);
    chk("mr_first_v", {7'b0, out_valid}, 8'd1);
    chk("mr_first", out, pick(8'd25, 8'd25));

    // Exhaustive, streamed at full throughput.
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("ex_v", {7'b0, out_valid}, 8'd1);
        chk($sformatf("ex_%0d", k-2), out, ref_mul(4'((k-2) >> 4), 4'((k-2) & 15)));
      end
      if (k < 256) drive(1'b1, 4'(k >> 4), 4'(k & 15));
      else         drive(1'b0, 4'd0, 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
